ring_osc_freq_meter: RTL and testbench
======================================

Name: ring_osc_freq_meter

Overview:
- Downstream consumer of the ring-oscillator divider output. The divider's MSB is asynchronous to clk.
- Synchronises that signal into the clk domain and counts its rising edges over a programmable gate window of clk cycles.
- Latches the result so the oscillator frequency can be read as count / gate_len × f_clk.
- Result is visible both as a parallel word and through a byte-wide mux for pin-limited readout.

Parameters:
- CNT_W, 16, width of edge counter and result register (≥ 4, ≤ 32).
- GATE_W, 16, width of gate-length input and gate down-counter.
- SYNC_STAGES, 2, flops in the osc_in synchroniser (≥ 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- osc_in  input  1  divided ring-oscillator signal; asynchronous to clk.
- start  input  1  single-cycle request to begin a measurement.
- abort  input  1  cancels a measurement in progress.
- gate_len  input  GATE_W  gate window length in clk cycles; sampled on accepted start.
- busy  output  1  high while in GATE.
- done  output  1  high while in DONE (result valid).
- overflow  output  1  result saturated during the last measurement.
- count  output  CNT_W  latched rising-edge count of the last completed measurement.
- byte_sel  input  2  selects byte of count for byte_out (0 = bits 7:0, 1 = 15:8, …).
- byte_out  output  8  combinational mux of count; bytes above CNT_W read as 0.

Behaviour:
- Reset (async): sync chain, edge-history flop, state = IDLE, acc, gate_rem, count, overflow, ovf_acc all 0. busy = done = 0.
- Synchroniser and edge detect:
  - osc_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~hist, a one-cycle pulse.
  - The chain runs in every state, never cleared except by reset.
- FSM states are IDLE, GATE, DONE.
- IDLE/DONE + start=1, gate_len≠0:
  - next state GATE; gate_rem ← gate_len; acc ← 0; ovf_acc ← 0.
  - count and overflow hold their previous values.
- IDLE/DONE + start=1, gate_len=0:
  - next state DONE; count ← 0; overflow ← 0.
- GATE, each cycle:
  - if rise: acc ← acc+1, saturating at 2^CNT_W−1. A rise arriving with acc already at max sets ovf_acc.
  - gate_rem decrements each cycle.
- GATE, cycle with gate_rem=1:
  - The rise of that cycle is included: count ← final acc; overflow ← final ovf_acc.
  - Next state DONE.
  - Exactly gate_len cycles are sampled, starting the cycle after start is accepted.
  - done rises the cycle after the last sampled cycle.
- start while in GATE is ignored.
- abort in GATE: next state IDLE; count and overflow unchanged; done = 0.
- abort in IDLE/DONE has no effect.
- abort and start in the same cycle: abort wins in GATE; start wins in IDLE/DONE.
- DONE holds until start; a new start restarts immediately (back-to-back measurements).
- Edge timing:
  - An osc_in rising edge appears as rise SYNC_STAGES+1 cycles later (nominal).
  - Edges closer than 2 clk cycles apart are undercounted; this is a documented limit: f_osc_in < f_clk/2.
- Reset asserted mid-GATE returns everything to the reset state immediately. No partial result is retained.

Test Plan:
- osc_in square wave, period 8 clk, free-running ≥ 20 cycles before start; gate_len=64 → done after 65 cycles from start; count=8 (±1 for phase); overflow=0; busy high exactly 64 cycles.
- gate_len=0, start → done next cycle; count=0; busy never asserts.
- CNT_W=4; osc_in period 2 clk; gate_len=40 → count=15, overflow=1. Rerun with gate_len=10 → count=5, overflow=0 (sticky cleared).
- Mid-measurement events: start pulsed again mid-GATE → ignored, window length unchanged. abort at cycle 20 of a 64-cycle gate → IDLE; count retains prior result; done=0.
- rst_n low mid-GATE → count=0, overflow=0, busy=0, done=0 asynchronously. Released measurement then completes normally.
- After count=0x1234: byte_sel=0 → byte_out=0x34; byte_sel=1 → 0x12; byte_sel=2 → 0x00.

Source files
------------

// File: rtl/ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_freq_meter
//  Description : Measures the frequency of the ring-oscillator divider output.
//                osc_in is synchronised into clk, its rising edges are counted
//                over a gate window of gate_len clk cycles, and the count is
//                latched so f_osc = count / gate_len * f_clk.
//  Ports       : clk, rst_n (async, active-low)
//                osc_in    - divided oscillator, asynchronous to clk
//                start     - begin a measurement (ignored while busy)
//                abort     - cancel a measurement in progress
//                gate_len  - window length in clk cycles, sampled on start
//                busy      - measurement window open
//                done      - result valid
//                overflow  - edge count saturated in the last measurement
//                count     - latched edge count
//                byte_sel  - byte index for byte_out
//                byte_out  - selected byte of count (zero above CNT_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  count,
    input  logic [1:0]        byte_sel,
    output logic [7:0]        byte_out
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_gate = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [CNT_W-1:0] c_acc_max = '1;

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_rise;
    logic [CNT_W-1:0]       r_acc;
    logic                   r_ovf_acc;
    logic [GATE_W-1:0]      r_gate_rem;
    logic [CNT_W-1:0]       w_acc_next;
    logic                   w_ovf_next;
    logic                   w_accept;
    logic                   w_accept_zero;
    logic                   w_abort;
    logic                   w_last;
    logic [31:0]            w_count_ext;

    // ------------------------------------------------------------------
    // Synchroniser plus history flop; runs in every state so an edge just
    // before start is neither lost nor double-counted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], osc_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Control decodes. Abort only counts in GATE, start only outside it,
    // so abort wins in GATE and start wins in IDLE/DONE by construction.
    assign w_accept      = start && (r_state != c_gate) && (gate_len != '0);
    assign w_accept_zero = start && (r_state != c_gate) && (gate_len == '0);
    assign w_abort       = abort && (r_state == c_gate);
    assign w_last        = (r_state == c_gate) && !abort
                           && (r_gate_rem == GATE_W'(1));

    // Saturating accumulate; the current cycle's rise is folded in so the
    // final window cycle is included in the latched result.
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf_acc;
        if (w_rise) begin
            if (r_acc == c_acc_max) begin
                w_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (w_accept) begin
                    w_state_next = c_gate;
                end else if (w_accept_zero) begin
                    w_state_next = c_done;
                end
            end
            c_gate: begin
                if (w_abort) begin
                    w_state_next = c_idle;
                end else if (w_last) begin
                    w_state_next = c_done;
                end
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_gate);
        done = (r_state == c_done);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_gate_rem <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
            r_gate_rem <= gate_len;
        end else if (w_accept_zero) begin
            count      <= '0;
            overflow   <= 1'b0;
        end else if ((r_state == c_gate) && !w_abort) begin
            r_acc      <= w_acc_next;
            r_ovf_acc  <= w_ovf_next;
            r_gate_rem <= r_gate_rem - GATE_W'(1);
            if (w_last) begin
                count    <= w_acc_next;
                overflow <= w_ovf_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte readout; bytes beyond CNT_W read as zero.
    // ------------------------------------------------------------------
    generate
        if (CNT_W < 32) begin : g_pad
            assign w_count_ext = {{(32-CNT_W){1'b0}}, count};
        end else begin : g_nopad
            assign w_count_ext = count;
        end
    endgenerate

    always_comb begin
        byte_out = 8'h00;
        case (byte_sel)
            2'd0:    byte_out = w_count_ext[7:0];
            2'd1:    byte_out = w_count_ext[15:8];
            2'd2:    byte_out = w_count_ext[23:16];
            default: byte_out = w_count_ext[31:24];
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_osc_freq_meter
//  Description : Directed self-checking bench for ring_osc_freq_meter. One
//                instance at default widths, one with a 4-bit counter for
//                saturation. osc inputs are derived from a free-running
//                negedge counter, giving exact edge counts per window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_osc_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] osc_div = 32'd0;
    logic        fast_a = 1'b0;

    logic        osc_a, start_a = 1'b0, abort_a = 1'b0;
    logic [15:0] gate_len_a = 16'd0;
    logic        busy_a, done_a, overflow_a;
    logic [15:0] count_a;
    logic [1:0]  byte_sel_a = 2'd0;
    logic [7:0]  byte_out_a;

    logic        osc_b, start_b = 1'b0, abort_b = 1'b0;
    logic [15:0] gate_len_b = 16'd0;
    logic        busy_b, done_b, overflow_b;
    logic [3:0]  count_b;
    logic [1:0]  byte_sel_b = 2'd1;
    logic [7:0]  byte_out_b;

    int n_checks = 0;
    int n_errors = 0;
    int nb;

    always #5 clk = ~clk;
    always @(negedge clk) osc_div <= osc_div + 32'd1;

    assign osc_a = fast_a ? osc_div[0] : osc_div[2];   // period 2 or 8 clk
    assign osc_b = osc_div[0];                          // period 2 clk

    ring_osc_freq_meter u_dut_a (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_a), .start(start_a),
        .abort(abort_a), .gate_len(gate_len_a), .busy(busy_a),
        .done(done_a), .overflow(overflow_a), .count(count_a),
        .byte_sel(byte_sel_a), .byte_out(byte_out_a)
    );

    ring_osc_freq_meter #(.CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_b), .start(start_b),
        .abort(abort_b), .gate_len(gate_len_b), .busy(busy_b),
        .done(done_b), .overflow(overflow_b), .count(count_b),
        .byte_sel(byte_sel_b), .byte_out(byte_out_b)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse start on instance A; leaves the bench one sample after the
    // accepting edge.
    task automatic start_meas_a(input logic [15:0] len);
        gate_len_a = len;
        start_a    = 1'b1;
        step(1);
        start_a    = 1'b0;
    endtask

    // Waits for done on A, counting sampled cycles with busy high.
    task automatic wait_done_a(input int limit, inout int nbusy);
        int k = 0;
        while (!done_a && k < limit) begin
            if (busy_a) nbusy++;
            step(1);
            k++;
        end
    endtask

    task automatic wait_done_b(input int limit);
        int k = 0;
        while (!done_b && k < limit) begin
            step(1);
            k++;
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        step(3);
        check_value("rst_busy",  32'(busy_a), 32'd0);
        check_value("rst_done",  32'(done_a), 32'd0);
        check_value("rst_count", 32'(count_a), 32'd0);
        rst_n = 1'b1;
        step(30);   // osc free-running well before the first start

        // ---------------- basic 64-cycle window, period 8 ----------------
        start_meas_a(16'd64);
        nb = 0;
        wait_done_a(200, nb);
        check_value("m64_busy_cycles", 32'(nb), 32'd64);
        check_value("m64_done",  32'(done_a), 32'd1);
        check_value("m64_count", 32'(count_a), 32'd8);
        check_value("m64_ovf",   32'(overflow_a), 32'd0);

        // ---------------- gate_len = 0 ----------------
        start_meas_a(16'd0);
        check_value("g0_done",  32'(done_a), 32'd1);
        check_value("g0_busy",  32'(busy_a), 32'd0);
        check_value("g0_count", 32'(count_a), 32'd0);

        // ---------------- start pulsed mid-GATE is ignored ----------------
        start_meas_a(16'd64);
        nb = 1;                          // the sample just taken was busy
        check_value("mid_busy0", 32'(busy_a), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (busy_a) nb++;
            step(1);
        end
        nb--;                            // first sample already counted
        gate_len_a = 16'd5;
        start_a    = 1'b1;
        if (busy_a) nb++;
        step(1);
        start_a    = 1'b0;
        gate_len_a = 16'd64;
        wait_done_a(200, nb);
        check_value("mid_busy_cycles", 32'(nb), 32'd64);
        check_value("mid_count", 32'(count_a), 32'd8);

        // ---------------- abort at cycle 20 ----------------
        start_meas_a(16'd64);
        step(19);
        abort_a = 1'b1;
        step(1);
        abort_a = 1'b0;
        check_value("abort_busy",  32'(busy_a), 32'd0);
        check_value("abort_done",  32'(done_a), 32'd0);
        check_value("abort_count", 32'(count_a), 32'd8);
        step(70);
        check_value("abort_stays_idle", 32'(done_a), 32'd0);

        // ---------------- async reset mid-GATE ----------------
        start_meas_a(16'd64);
        step(10);
        rst_n = 1'b0;
        #1;
        check_value("arst_count", 32'(count_a), 32'd0);
        check_value("arst_ovf",   32'(overflow_a), 32'd0);
        check_value("arst_busy",  32'(busy_a), 32'd0);
        check_value("arst_done",  32'(done_a), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(20);
        start_meas_a(16'd64);
        nb = 0;
        wait_done_a(200, nb);
        check_value("post_rst_busy",  32'(nb), 32'd64);
        check_value("post_rst_count", 32'(count_a), 32'd8);

        // ---------------- abort+start together ----------------
        start_meas_a(16'd64);
        step(4);
        abort_a = 1'b1; start_a = 1'b1;
        step(1);
        abort_a = 1'b0; start_a = 1'b0;
        check_value("as_gate_busy", 32'(busy_a), 32'd0);
        check_value("as_gate_done", 32'(done_a), 32'd0);
        check_value("as_gate_count", 32'(count_a), 32'd8);
        gate_len_a = 16'd0;
        abort_a = 1'b1; start_a = 1'b1;
        step(1);
        abort_a = 1'b0; start_a = 1'b0;
        check_value("as_idle_done",  32'(done_a), 32'd1);
        check_value("as_idle_count", 32'(count_a), 32'd0);

        // ---------------- CNT_W = 4 saturation ----------------
        gate_len_b = 16'd40;
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        wait_done_b(200);
        check_value("sat_done",  32'(done_b), 32'd1);
        check_value("sat_count", 32'(count_b), 32'd15);
        check_value("sat_ovf",   32'(overflow_b), 32'd1);
        check_value("sat_byte1", 32'(byte_out_b), 32'd0);
        gate_len_b = 16'd10;             // back-to-back from DONE
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        check_value("b2b_busy", 32'(busy_b), 32'd1);
        wait_done_b(200);
        check_value("nosat_count", 32'(count_b), 32'd5);
        check_value("nosat_ovf",   32'(overflow_b), 32'd0);
        byte_sel_b = 2'd0;
        #1;
        check_value("nosat_byte0", 32'(byte_out_b), 32'd5);

        // ---------------- count = 0x1234 and byte readout ----------------
        fast_a = 1'b1;
        step(10);
        start_meas_a(16'd9320);          // 9320 cycles / period 2 = 4660
        nb = 0;
        wait_done_a(10000, nb);
        check_value("big_count", 32'(count_a), 32'h1234);
        check_value("big_ovf",   32'(overflow_a), 32'd0);
        byte_sel_a = 2'd0; #1;
        check_value("byte0", 32'(byte_out_a), 32'h34);
        byte_sel_a = 2'd1; #1;
        check_value("byte1", 32'(byte_out_a), 32'h12);
        byte_sel_a = 2'd2; #1;
        check_value("byte2", 32'(byte_out_a), 32'h00);
        byte_sel_a = 2'd3; #1;
        check_value("byte3", 32'(byte_out_a), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
